// File: rtl/rx_chan_scheduler.sv
// rtl/rx_chan_scheduler.sv - round-robin RX FIFO slot scheduler for the packet builder
//
// Purpose:
//   Polls slots 0..L one per cycle, where L = min(channels, NUM_CHAN). Slot 0 is
//   the command/control FIFO and slots 1..NUM_CHAN are ADC channels. A slot that
//   qualifies while the USB side has space is offered to the packet builder over
//   a valid/ack handshake. A slot that qualifies while there is no space sets a
//   sticky overrun flag instead.
//
// Optional feature:
//   SCHED_STARVE_GUARD_EN - per-data-slot starvation counters that force a
//   partial slot out after STARVE_LIMIT visits, even without flush.
//
// Ports:
//   rxclk        clock, all state on the rising edge
//   reset        asynchronous active-low reset
//   channels     highest slot index to poll (clamped to NUM_CHAN)
//   chan_usedw   packed per-slot used-word counts, slot k at [k*USEDW_W +: USEDW_W]
//   chan_empty   per-slot FIFO empty flags
//   have_space   USB-side FIFO can take a full packet
//   flush        level; any non-empty slot qualifies while high
//   ack          builder accepts the current offer
//   pkt_done     pulse; builder finished the granted packet
//   req_valid    offer pending
//   req_sel      slot index offered
//   req_partial  offered slot was below THRESHOLD at grant time
//   overrun      sticky per-slot overrun flags
//   busy         high while an offer or packet is outstanding

module rx_chan_scheduler #(
   parameter int NUM_CHAN     = 4,
   parameter int USEDW_W      = 10,
   parameter int THRESHOLD    = 504,
   parameter int STARVE_LIMIT = 64
) (
   input  logic                              rxclk,
   input  logic                              reset,
   input  logic [3:0]                        channels,
   input  logic [(NUM_CHAN+1)*USEDW_W-1:0]   chan_usedw,
   input  logic [NUM_CHAN:0]                 chan_empty,
   input  logic                              have_space,
   input  logic                              flush,
   input  logic                              ack,
   input  logic                              pkt_done,
   output logic                              req_valid,
   output logic [3:0]                        req_sel,
   output logic                              req_partial,
   output logic [NUM_CHAN:0]                 overrun,
   output logic                              busy
);

   localparam int                 S        = NUM_CHAN + 1;
   localparam logic [3:0]         MAX_SLOT = 4'(NUM_CHAN);
   localparam logic [USEDW_W-1:0] THR      = USEDW_W'(THRESHOLD);

   // Parameter sanity: slot indices travel on 4-bit buses, the threshold must be
   // representable in a used-word count, and the starve counters are 8 bits.
   if (NUM_CHAN < 1 || NUM_CHAN > 15) begin : g_bad_num_chan
      $error("rx_chan_scheduler: NUM_CHAN must be 1..15");
   end
   if (THRESHOLD < 1 || THRESHOLD >= (1 << USEDW_W)) begin : g_bad_threshold
      $error("rx_chan_scheduler: THRESHOLD must fit in USEDW_W bits");
   end
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
      $error("rx_chan_scheduler: STARVE_LIMIT must be 1..255");
   end

   typedef enum logic [1:0] {
      ST_SCAN   = 2'd0,
      ST_OFFER  = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nx;

   logic [3:0] ptr;
   logic [3:0] limit;
   logic [3:0] ptr_adv;
   logic [3:0] sel_adv;

   // Per-slot decode, padded to 16 entries so a 4-bit pointer always indexes in range.
   logic [15:0] slot_full;
   logic [15:0] slot_qual;
   logic [15:0] starved;

   logic       cur_qual;
   logic       grant;
   logic       ovr_hit;
   logic       ack_take;

   // Effective poll limit and the shared wrap rule. A pointer left above a
   // lowered limit wraps to 0 on its next advance.
   always_comb begin
      limit   = (channels > MAX_SLOT) ? MAX_SLOT : channels;
      ptr_adv = (ptr >= limit)     ? 4'd0 : ptr + 4'd1;
      sel_adv = (req_sel >= limit) ? 4'd0 : req_sel + 4'd1;
   end

   always_comb begin
      slot_full = '0;
      slot_qual = '0;
      for (int k = 0; k < S; k++) begin
         slot_full[k] = (chan_usedw[k*USEDW_W +: USEDW_W] >= THR);
         slot_qual[k] = ~chan_empty[k] &&
                        ((k == 0) || slot_full[k] || flush || starved[k]);
      end
   end

   assign cur_qual = slot_qual[ptr];
   assign grant    = (state == ST_SCAN) && cur_qual && have_space;
   assign ovr_hit  = (state == ST_SCAN) && cur_qual && !have_space;
   assign ack_take = (state == ST_OFFER) && ack;

`ifdef SCHED_STARVE_GUARD_EN
   // Starvation guard: count SCAN visits of a non-empty, below-threshold data
   // slot. Emptying or granting the slot resets its count.
   logic [7:0] starve_cnt [NUM_CHAN:1];

   always_ff @(posedge rxclk or negedge reset) begin
      if (!reset) begin
         for (int k = 1; k <= NUM_CHAN; k++) starve_cnt[k] <= 8'd0;
      end else begin
         for (int k = 1; k <= NUM_CHAN; k++) begin
            if (chan_empty[k] || (grant && ptr == 4'(k))) begin
               starve_cnt[k] <= 8'd0;
            end else if (state == ST_SCAN && ptr == 4'(k) && !slot_full[k] &&
                         starve_cnt[k] != 8'hFF) begin
               starve_cnt[k] <= starve_cnt[k] + 8'd1;
            end
         end
      end
   end

   always_comb begin
      starved = '0;
      for (int k = 1; k <= NUM_CHAN; k++) begin
         starved[k] = (starve_cnt[k] >= 8'(STARVE_LIMIT));
      end
   end
`else
   assign starved = '0;
`endif

   // FSM: state register
   always_ff @(posedge rxclk or negedge reset) begin
      if (!reset) state <= ST_SCAN;
      else        state <= state_nx;
   end

   // FSM: next state. pkt_done is ignored while offering and ack while waiting.
   always_comb begin
      state_nx = state;
      case (state)
         ST_SCAN:  if (grant)    state_nx = ST_OFFER;
         ST_OFFER: if (ack)      state_nx = ST_WAIT;
         ST_WAIT:  if (pkt_done) state_nx = ST_SCAN;
         default:                state_nx = ST_SCAN;
      endcase
   end

   // FSM: outputs. An illegal encoding drives neither valid nor busy.
   always_comb begin
      req_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         ST_OFFER: begin
            req_valid = 1'b1;
            busy      = 1'b1;
         end
         ST_WAIT:  busy = 1'b1;
         default:  ;
      endcase
   end

   // Scan pointer and offer latch. The pointer holds on a grant so the slot
   // being serviced is the reference for the post-packet advance.
   always_ff @(posedge rxclk or negedge reset) begin
      if (!reset) begin
         ptr         <= 4'd0;
         req_sel     <= 4'd0;
         req_partial <= 1'b0;
      end else begin
         case (state)
            ST_SCAN: begin
               if (grant) begin
                  req_sel     <= ptr;
                  req_partial <= ~slot_full[ptr];
               end else begin
                  ptr <= ptr_adv;
               end
            end
            ST_WAIT: if (pkt_done) ptr <= sel_adv;
            default: ;
         endcase
      end
   end

   // Sticky overrun flags: set when a qualified slot finds no USB space,
   // cleared when the builder accepts that slot. Clear wins a same-cycle tie.
   always_ff @(posedge rxclk or negedge reset) begin
      if (!reset) begin
         overrun <= '0;
      end else begin
         for (int k = 0; k < S; k++) begin
            if (ack_take && req_sel == 4'(k))    overrun[k] <= 1'b0;
            else if (ovr_hit && ptr == 4'(k))    overrun[k] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rx_chan_scheduler.sv
// tb/tb_rx_chan_scheduler.sv - directed and randomized bench for rx_chan_scheduler

module tb_rx_chan_scheduler;

   localparam int NCH = 4;
   localparam int S   = NCH + 1;
   localparam int UW  = 10;
   localparam int THR = 504;

   logic              rxclk = 1'b0;
   logic              reset;
   logic [3:0]        channels;
   logic [S*UW-1:0]   chan_usedw;
   logic [S-1:0]      chan_empty;
   logic              have_space;
   logic              flush;
   logic              ack;
   logic              pkt_done;
   logic              req_valid;
   logic [3:0]        req_sel;
   logic              req_partial;
   logic [S-1:0]      overrun;
   logic              busy;

   logic [UW-1:0]     usedw_arr [0:S-1];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: which phase of the service cycle we are in, the slot the
   // scheduler will look at next, the slot on offer and the overrun flags.
   int          m_mode;   // 0 polling, 1 offering, 2 waiting for packet end
   int          m_ptr;
   int          m_sel;
   bit          m_part;
   bit [S-1:0]  m_ovr;

   always #5 rxclk = ~rxclk;

   always_comb begin
      chan_usedw = '0;
      for (int k = 0; k < S; k++) chan_usedw[k*UW +: UW] = usedw_arr[k];
   end

   rx_chan_scheduler #(
      .NUM_CHAN(NCH), .USEDW_W(UW), .THRESHOLD(THR), .STARVE_LIMIT(64)
   ) dut (
      .rxclk(rxclk), .reset(reset), .channels(channels), .chan_usedw(chan_usedw),
      .chan_empty(chan_empty), .have_space(have_space), .flush(flush), .ack(ack),
      .pkt_done(pkt_done), .req_valid(req_valid), .req_sel(req_sel),
      .req_partial(req_partial), .overrun(overrun), .busy(busy)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int eff_limit();
      return (int'(channels) > NCH) ? NCH : int'(channels);
   endfunction

   function automatic int next_slot(input int p);
      return (p >= eff_limit()) ? 0 : p + 1;
   endfunction

   function automatic bit qualifies(input int k);
      if (k > NCH) return 1'b0;
      return !chan_empty[k] && (k == 0 || int'(usedw_arr[k]) >= THR || flush);
   endfunction

   task automatic model_reset();
      m_mode = 0; m_ptr = 0; m_sel = 0; m_part = 1'b0; m_ovr = '0;
   endtask

   task automatic model_step();
      if (!reset) begin
         model_reset();
         return;
      end
      case (m_mode)
         0: begin
            if (qualifies(m_ptr) && have_space) begin
               m_sel  = m_ptr;
               m_part = int'(usedw_arr[m_ptr]) < THR;
               m_mode = 1;
            end else begin
               if (qualifies(m_ptr)) m_ovr[m_ptr] = 1'b1;
               m_ptr = next_slot(m_ptr);
            end
         end
         1: if (ack) begin
            m_ovr[m_sel] = 1'b0;
            m_mode = 2;
         end
         default: if (pkt_done) begin
            m_ptr  = next_slot(m_sel);
            m_mode = 0;
         end
      endcase
   endtask

   task automatic compare_all();
      check_val("req_valid", 32'(req_valid), 32'(m_mode == 1));
      check_val("busy", 32'(busy), 32'(m_mode != 0));
      check_val("req_sel", 32'(req_sel), 32'(m_sel));
      check_val("req_partial", 32'(req_partial), 32'(m_part));
      check_val("overrun", 32'(overrun), 32'(m_ovr));
   endtask

   task automatic tick();
      @(posedge rxclk);
      model_step();
      @(negedge rxclk);
      compare_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_offer(input int max_cycles);
      for (int i = 0; i < max_cycles && !req_valid; i++) tick();
   endtask

   task automatic set_slot(input int k, input bit empty, input int words);
      chan_empty[k] = empty;
      usedw_arr[k]  = UW'(words);
   endtask

   task automatic clear_slots();
      for (int k = 0; k < S; k++) set_slot(k, 1'b1, 0);
   endtask

   // Called at a falling edge: pulse reset low between edges and check that
   // outputs drop without waiting for the clock.
   task automatic async_reset(input string tag);
      #2 reset = 1'b0;
      #1;
      check_val({tag, "_valid"}, 32'(req_valid), 32'd0);
      check_val({tag, "_busy"}, 32'(busy), 32'd0);
      check_val({tag, "_ovr"}, 32'(overrun), 32'd0);
      model_reset();
      @(negedge rxclk);
      reset = 1'b1;
   endtask

   function automatic int pick_words();
      case ($urandom_range(0, 7))
         0: return 0;
         1: return 10;
         2: return THR - 1;
         3: return THR;
         4: return THR + 1;
         5: return 600;
         6: return 1023;
         default: return int'($urandom_range(0, 1023));
      endcase
   endfunction

   initial begin
      reset = 1'b0;
      channels = 4'd4;
      have_space = 1'b1;
      flush = 1'b0;
      ack = 1'b0;
      pkt_done = 1'b0;
      clear_slots();
      model_reset();
      @(negedge rxclk);
      @(negedge rxclk);
      compare_all();
      check_val("rst_valid", 32'(req_valid), 32'd0);
      check_val("rst_ovr", 32'(overrun), 32'd0);
      reset = 1'b1;

      // All empty: a full pass of the ring with nothing offered.
      ticks(6);
      check_val("idle_valid", 32'(req_valid), 32'd0);

      // Pointer now at slot 1; full slot 2 is offered one cycle after it is reached.
      set_slot(2, 1'b0, THR);
      tick();
      check_val("s2_before", 32'(req_valid), 32'd0);
      tick();
      check_val("s2_valid", 32'(req_valid), 32'd1);
      check_val("s2_sel", 32'(req_sel), 32'd2);
      check_val("s2_part", 32'(req_partial), 32'd0);
      ack = 1'b1; tick(); ack = 1'b0;
      check_val("s2_acked", 32'(req_valid), 32'd0);
      check_val("s2_busy", 32'(busy), 32'd1);
      set_slot(3, 1'b0, THR);
      pkt_done = 1'b1; tick(); pkt_done = 1'b0;
      check_val("s2_done", 32'(busy), 32'd0);
      tick();
      check_val("after2_sel", 32'(req_sel), 32'd3);
      ack = 1'b1; tick(); ack = 1'b0;
      pkt_done = 1'b1; tick(); pkt_done = 1'b0;
      clear_slots();

      // No USB space: overrun on slot 1 is sticky until slot 1 is accepted.
      set_slot(1, 1'b0, 600);
      have_space = 1'b0;
      ticks(15);
      check_val("ovr1_set", 32'(overrun[1]), 32'd1);
      have_space = 1'b1;
      wait_offer(10);
      check_val("ovr1_valid", 32'(req_valid), 32'd1);
      check_val("ovr1_sel", 32'(req_sel), 32'd1);
      check_val("ovr1_held", 32'(overrun[1]), 32'd1);
      ack = 1'b1; tick(); ack = 1'b0;
      check_val("ovr1_clr", 32'(overrun[1]), 32'd0);
      pkt_done = 1'b1; tick(); pkt_done = 1'b0;
      clear_slots();

      // Partial slot only goes out under flush.
      set_slot(3, 1'b0, 10);
      ticks(20);
      check_val("part_idle", 32'(req_valid), 32'd0);
      flush = 1'b1;
      wait_offer(10);
      check_val("flush_sel", 32'(req_sel), 32'd3);
      check_val("flush_part", 32'(req_partial), 32'd1);
      flush = 1'b0;

      // Slot 0 and slot 4 both ready with the pointer landing on 4.
      set_slot(4, 1'b0, THR);
      set_slot(0, 1'b0, 5);
      ack = 1'b1; tick(); ack = 1'b0;
      set_slot(3, 1'b1, 0);
      pkt_done = 1'b1; tick(); pkt_done = 1'b0;
      tick();
      check_val("wrap_first", 32'(req_sel), 32'd4);
      ack = 1'b1; tick(); ack = 1'b0;
      pkt_done = 1'b1; tick(); pkt_done = 1'b0;
      tick();
      check_val("wrap_second", 32'(req_sel), 32'd0);
      check_val("wrap_part", 32'(req_partial), 32'd1);
      ack = 1'b1; tick(); ack = 1'b0;
      clear_slots();
      pkt_done = 1'b1; tick(); pkt_done = 1'b0;

      // Reset while waiting for packet end, with an overrun still pending.
      set_slot(1, 1'b0, THR);
      set_slot(2, 1'b0, THR);
      have_space = 1'b0;
      ticks(12);
      check_val("pre_rst_ovr", 32'(overrun[2:1]), 32'd3);
      have_space = 1'b1;
      wait_offer(10);
      ack = 1'b1; tick(); ack = 1'b0;
      check_val("wait_busy", 32'(busy), 32'd1);
      async_reset("wd_rst");
      clear_slots();

      // Lowered channel count: slots 3 and 4 are never examined.
      channels = 4'd2;
      set_slot(3, 1'b0, THR);
      set_slot(4, 1'b0, THR);
      have_space = 1'b0;
      ticks(30);
      check_val("chan2_ovr", 32'(overrun), 32'd0);
      check_val("chan2_valid", 32'(req_valid), 32'd0);
      have_space = 1'b1;
      channels = 4'd4;

      // Randomized traffic against the reference.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 49) == 0) channels = 4'($urandom_range(0, 15));
         for (int k = 0; k < S; k++) begin
            if ($urandom_range(0, 3) == 0)
               set_slot(k, 1'($urandom_range(0, 1)), pick_words());
         end
         have_space = ($urandom_range(0, 9) < 8);
         flush      = ($urandom_range(0, 9) == 0);
         ack        = ($urandom_range(0, 1) == 1);
         pkt_done   = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 299) == 0) async_reset("rnd_rst");
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
